// File: rtl/sonar_varredura_uc.sv
// rtl/sonar_varredura_uc.sv - sonar sweep/measure/transmit sequencing controller
//
// Steps the servo through a ping-pong sweep 0,1,..,N-1,N-2,..,0,1,..
// It fires one HC-SR04 measurement per position. Each result is latched
// together with its position and handed to the TX serializer.
//
// Optional feature: define SONAR_TIMEOUT_EN to bound the wait for `pronto`
// to T_TIMEOUT cycles. Without it the wait is unbounded and `erro` is 0.
//
// Parameters:
//   N_POSICOES  number of sweep positions (2..8)
//   T_SERVO     settling cycles after each position change
//   T_TIMEOUT   max cycles waiting for `pronto` (timeout build only)
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   ligar             level, sweep runs while high
//   pronto, medida    measurement-done pulse and 12-bit distance
//   fim_tx            TX word-consumed pulse
//   medir             one-cycle trigger to the sensor interface
//   posicao           current servo position index
//   distancia,angulo  last measurement and the position it was taken at
//   erro              last measurement timed out
//   transmitir        one-cycle strobe to TX, angulo/distancia/erro valid
//   ativo             high outside `inicial`
//   db_estado         state code, 4'hE for unused encodings
module sonar_varredura_uc #(
    parameter int N_POSICOES = 8,
    parameter int T_SERVO    = 25_000_000,
    parameter int T_TIMEOUT  = 2_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic [11:0] medida,
    input  logic        fim_tx,
    output logic        medir,
    output logic [2:0]  posicao,
    output logic [11:0] distancia,
    output logic [2:0]  angulo,
    output logic        erro,
    output logic        transmitir,
    output logic        ativo,
    output logic [3:0]  db_estado
);

    localparam logic [3:0] ST_INICIAL   = 4'd0;
    localparam logic [3:0] ST_PREPARA   = 4'd1;
    localparam logic [3:0] ST_POSICIONA = 4'd2;
    localparam logic [3:0] ST_DISPARA   = 4'd3;
    localparam logic [3:0] ST_AGUARDA   = 4'd4;
    localparam logic [3:0] ST_REGISTRA  = 4'd5;
    localparam logic [3:0] ST_TRANSMITE = 4'd6;
    localparam logic [3:0] ST_ESPERA_TX = 4'd7;
    localparam logic [3:0] ST_PROXIMA   = 4'd8;

    localparam logic [25:0] SERVO_LAST = 26'(T_SERVO - 1);
    // The counter holds at the longer of the two waits it times, so it can
    // never wrap back into a terminal count.
    localparam logic [25:0] CNT_LIMIT  = 26'((T_SERVO > T_TIMEOUT) ? T_SERVO : T_TIMEOUT);
    localparam logic [2:0]  POS_TOP    = 3'(N_POSICOES - 1);
    localparam logic [2:0]  POS_BELOW  = 3'(N_POSICOES - 2);

    logic [3:0]  estado;
    logic [3:0]  estado_prox;
    logic [25:0] cnt;
    logic        descendo;
    logic        cnt_run;
    logic        timeout;

`ifdef SONAR_TIMEOUT_EN
    localparam logic [25:0] TIMEOUT_LAST = 26'(T_TIMEOUT - 1);
    logic erro_r;

    assign cnt_run = (estado == ST_POSICIONA) || (estado == ST_AGUARDA);
    assign timeout = (estado == ST_AGUARDA) && (cnt == TIMEOUT_LAST);
    assign erro    = erro_r;
`else
    assign cnt_run = (estado == ST_POSICIONA);
    assign timeout = 1'b0;
    assign erro    = 1'b0;
`endif

    always_comb begin
        estado_prox = ST_INICIAL;
        case (estado)
            ST_INICIAL:   estado_prox = ligar ? ST_PREPARA : ST_INICIAL;
            ST_PREPARA:   estado_prox = ST_POSICIONA;
            ST_POSICIONA: estado_prox = (cnt == SERVO_LAST) ? ST_DISPARA : ST_POSICIONA;
            ST_DISPARA:   estado_prox = ST_AGUARDA;
            ST_AGUARDA:   estado_prox = (pronto || timeout) ? ST_REGISTRA : ST_AGUARDA;
            ST_REGISTRA:  estado_prox = ST_TRANSMITE;
            ST_TRANSMITE: estado_prox = ST_ESPERA_TX;
            ST_ESPERA_TX: estado_prox = fim_tx ? ST_PROXIMA : ST_ESPERA_TX;
            ST_PROXIMA:   estado_prox = ligar ? ST_POSICIONA : ST_INICIAL;
            default:      estado_prox = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= ST_INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Wait counter: runs only in the timed states and restarts from zero
    // on every entry, which covers the clears in prepara and dispara.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_run) begin
            if (cnt != CNT_LIMIT) begin
                cnt <= cnt + 26'd1;
            end
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            posicao   <= '0;
            descendo  <= 1'b0;
            distancia <= '0;
            angulo    <= '0;
        end else begin
            case (estado)
                ST_PREPARA: descendo <= 1'b0;
                ST_AGUARDA: begin
                    // pronto takes priority over a simultaneous timeout
                    if (pronto) begin
                        distancia <= medida;
                    end else if (timeout) begin
                        distancia <= 12'hFFF;
                    end
                end
                ST_REGISTRA: angulo <= posicao;
                ST_PROXIMA: begin
                    if (!descendo) begin
                        if (posicao == POS_TOP) begin
                            descendo <= 1'b1;
                            posicao  <= POS_BELOW;
                        end else begin
                            posicao  <= posicao + 3'd1;
                        end
                    end else begin
                        if (posicao == 3'd0) begin
                            descendo <= 1'b0;
                            posicao  <= 3'd1;
                        end else begin
                            posicao  <= posicao - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SONAR_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erro_r <= 1'b0;
        end else if (estado == ST_AGUARDA) begin
            if (pronto) begin
                erro_r <= 1'b0;
            end else if (timeout) begin
                erro_r <= 1'b1;
            end
        end
    end
`endif

    assign medir      = (estado == ST_DISPARA);
    assign transmitir = (estado == ST_TRANSMITE);
    assign ativo      = (estado != ST_INICIAL);
    assign db_estado  = (estado > ST_PROXIMA) ? 4'hE : estado;

endmodule

// File: tb/tb_sonar_varredura_uc.sv
// tb/tb_sonar_varredura_uc.sv - self-checking bench for sonar_varredura_uc
`timescale 1ns/1ps
module tb_sonar_varredura_uc;

    localparam int N  = 4;
    localparam int TS = 4;
    localparam int TT = 20;
    localparam int P  = 2 * (N - 1);

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        pronto;
    logic [11:0] medida;
    logic        fim_tx;
    logic        medir;
    logic [2:0]  posicao;
    logic [11:0] distancia;
    logic [2:0]  angulo;
    logic        erro;
    logic        transmitir;
    logic        ativo;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;
    int sweep_idx = 0;

    typedef struct {
        int          pd;
        logic [11:0] med;
        int          fd;
        logic [2:0]  ang;
    } vec_t;

    vec_t tab [8];

    always #5 clock = ~clock;

    sonar_varredura_uc #(
        .N_POSICOES(N),
        .T_SERVO   (TS),
        .T_TIMEOUT (TT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ligar     (ligar),
        .pronto    (pronto),
        .medida    (medida),
        .fim_tx    (fim_tx),
        .medir     (medir),
        .posicao   (posicao),
        .distancia (distancia),
        .angulo    (angulo),
        .erro      (erro),
        .transmitir(transmitir),
        .ativo     (ativo),
        .db_estado (db_estado)
    );

    // Reference sweep: position of the s-th measurement of a ping-pong
    // sweep that starts at 0 going up.
    function automatic logic [2:0] ang_of(input int s);
        int r;
        r = s % P;
        return (r < N) ? 3'(r) : 3'(P - r);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_medir(input string name, input int exp);
        int n;
        n = 0;
        while (medir !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    // Called on a medir cycle; ends on the transmitir cycle.
    task automatic meas_to_tx(input int pd, input logic [11:0] med, input logic spur, input logic drop);
        logic [2:0] ea;
        ea = ang_of(sweep_idx);
        chk("medir_pos", 32'(posicao), 32'(ea));
        for (int i = 0; i < pd; i++) begin
            if (i == 1) begin
                if (spur) fim_tx = 1'b1;
                if (drop) ligar = 1'b0;
            end
            tick();
            if (i == 1 && spur) begin
                fim_tx = 1'b0;
                chk("spur_fim_state", 32'(db_estado), 32'(4));
                chk("spur_fim_tx", 32'(transmitir), 32'(0));
            end
        end
        pronto = 1'b1;
        medida = med;
        tick();
        pronto = 1'b0;
        medida = 12'($urandom);
        chk("dist_k1", 32'(distancia), 32'(med));
        tick();
        chk("tx_pulse", 32'(transmitir), 32'(1));
        chk("tx_angulo", 32'(angulo), 32'(ea));
        chk("tx_dist", 32'(distancia), 32'(med));
        chk("tx_erro", 32'(erro), 32'(0));
    endtask

    // Called on the transmitir cycle; ends on the next medir cycle, or idle
    // in inicial when ligar was dropped.
    task automatic tx_to_medir(input int fd, input logic spur, input logic [11:0] prev_med);
        int n;
        int cnt_medir;
        for (int i = 0; i < fd; i++) begin
            tick();
            if (i == 0) chk("tx_one_cycle", 32'(transmitir), 32'(0));
        end
        fim_tx = 1'b1;
        tick();
        fim_tx = 1'b0;
        sweep_idx++;
        if (ligar) begin
            n = 1;
            while (medir !== 1'b1 && n < 200) begin
                if (spur && n == 2) begin
                    pronto = 1'b1;
                    medida = 12'hABC;
                end
                tick();
                n++;
                if (spur && n == 3) begin
                    pronto = 1'b0;
                    chk("spur_pronto_state", 32'(db_estado), 32'(2));
                    chk("spur_pronto_dist", 32'(distancia), 32'(prev_med));
                end
            end
            chk("medir_lat", 32'(n), 32'(2 + TS));
        end else begin
            tick();
            chk("stop_state", 32'(db_estado), 32'(0));
            chk("stop_ativo", 32'(ativo), 32'(0));
            chk("stop_pos", 32'(posicao), 32'(ang_of(sweep_idx)));
            cnt_medir = 0;
            repeat (30) begin
                tick();
                if (medir === 1'b1) cnt_medir++;
            end
            chk("idle_medir", 32'(cnt_medir), 32'(0));
            sweep_idx = int'(ang_of(sweep_idx));
        end
    endtask

    initial begin
        int          n;
        int          pd;
        int          fd;
        logic        spur;
        logic        drop;
        logic [11:0] med;

        tab[0] = '{10, 12'h123, 3, 3'd0};
        tab[1] = '{10, 12'h123, 3, 3'd1};
        tab[2] = '{10, 12'h123, 3, 3'd2};
        tab[3] = '{10, 12'h123, 3, 3'd3};
        tab[4] = '{10, 12'h123, 3, 3'd2};
        tab[5] = '{10, 12'h123, 3, 3'd1};
        tab[6] = '{10, 12'h123, 3, 3'd0};
        tab[7] = '{10, 12'h123, 3, 3'd1};

        reset  = 1'b1;
        ligar  = 1'b0;
        pronto = 1'b0;
        fim_tx = 1'b0;
        medida = 12'h0;
        repeat (2) tick();
        chk("rst_medir", 32'(medir), 32'(0));
        chk("rst_transmitir", 32'(transmitir), 32'(0));
        chk("rst_erro", 32'(erro), 32'(0));
        chk("rst_ativo", 32'(ativo), 32'(0));
        chk("rst_posicao", 32'(posicao), 32'(0));
        chk("rst_angulo", 32'(angulo), 32'(0));
        chk("rst_distancia", 32'(distancia), 32'(0));
        chk("rst_estado", 32'(db_estado), 32'(0));
        reset = 1'b0;
        tick();
        chk("idle_estado", 32'(db_estado), 32'(0));

        // Sweep from the test plan: first medir 2+T_SERVO after ligar.
        ligar = 1'b1;
        wait_medir("first_medir", 2 + TS);
        for (int v = 0; v < 8; v++) begin
            chk("tab_ang", 32'(ang_of(sweep_idx)), 32'(tab[v].ang));
            meas_to_tx(tab[v].pd, tab[v].med, 1'b0, 1'b0);
            tx_to_medir(tab[v].fd, 1'b0, tab[v].med);
        end

        // Spurious fim_tx in aguarda, spurious pronto in posiciona.
        meas_to_tx(6, 12'h3C5, 1'b1, 1'b0);
        tx_to_medir(2, 1'b1, 12'h3C5);

        // Reset in espera_tx at position 3.
        meas_to_tx(4, 12'h077, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_rst_pos", 32'(posicao), 32'(3));
        reset = 1'b1;
        tick();
        chk("mid_rst_estado", 32'(db_estado), 32'(0));
        chk("mid_rst_pos", 32'(posicao), 32'(0));
        chk("mid_rst_tx", 32'(transmitir), 32'(0));
        reset = 1'b0;
        sweep_idx = 0;
        wait_medir("restart_medir", 2 + TS);
        meas_to_tx(5, 12'h200, 1'b0, 1'b0);
        tx_to_medir(1, 1'b0, 12'h200);
        meas_to_tx(5, 12'h201, 1'b0, 1'b0);
        tx_to_medir(1, 1'b0, 12'h201);

`ifdef SONAR_TIMEOUT_EN
        // No pronto: timeout after TT cycles in aguarda.
        chk("to_pos", 32'(posicao), 32'(ang_of(sweep_idx)));
        n = 0;
        while (transmitir !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'(TT + 2));
        chk("to_dist", 32'(distancia), 32'(12'hFFF));
        chk("to_erro", 32'(erro), 32'(1));
        chk("to_angulo", 32'(angulo), 32'(ang_of(sweep_idx)));
        tx_to_medir(2, 1'b0, 12'hFFF);
        meas_to_tx(5, 12'h456, 1'b0, 1'b0);
        tx_to_medir(2, 1'b0, 12'h456);
        // pronto on the last counted cycle wins over the timeout.
        meas_to_tx(TT, 12'h789, 1'b0, 1'b0);
        tx_to_medir(2, 1'b0, 12'h789);
`endif

        // ligar dropped in aguarda: finish, advance once, stop.
        meas_to_tx(7, 12'h5A5, 1'b0, 1'b1);
        tx_to_medir(2, 1'b0, 12'h5A5);

        // Randomized sweep against the reference model.
        ligar = 1'b1;
        wait_medir("rand_start", 2 + TS);
        for (int r = 0; r < 30; r++) begin
            pd   = int'($urandom_range(3, 15));
            fd   = int'($urandom_range(1, 6));
            med  = 12'($urandom);
            spur = ($urandom_range(0, 3) == 0);
            drop = ($urandom_range(0, 5) == 0);
            meas_to_tx(pd, med, spur, drop);
            tx_to_medir(fd, spur & ~drop, med);
            if (drop) begin
                ligar = 1'b1;
                wait_medir("rand_restart", 2 + TS);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
